// File: rtl/mmu_l2tlb_pkg.sv
// Shared types and helpers for the L2 TLB set refill controller.
// Covers the FSM state encoding, the one-hot way constants and a one-hot test.
package mmu_l2tlb_pkg;

    localparam int WAYS = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        WRITE  = 2'd2
    } state_e;

    localparam logic [WAYS-1:0] WAY0 = 4'b0001;
    localparam logic [WAYS-1:0] WAY1 = 4'b0010;
    localparam logic [WAYS-1:0] WAY2 = 4'b0100;
    localparam logic [WAYS-1:0] WAY3 = 4'b1000;

    function automatic logic is_onehot4(input logic [WAYS-1:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/mmu_l2tlb_victim_sel.sv
// Victim way choice for a refill: the lowest invalid way wins, otherwise the PLRU
// suggestion is used, falling back to way 0 when that suggestion is not one-hot.
module mmu_l2tlb_victim_sel
    import mmu_l2tlb_pkg::*;
(
    input  logic [WAYS-1:0] valid_4,
    input  logic [WAYS-1:0] replace_way_4,
    output logic [WAYS-1:0] victim_4
);

    always_comb begin
        victim_4 = WAY0;
        if (!valid_4[0]) begin
            victim_4 = WAY0;
        end else if (!valid_4[1]) begin
            victim_4 = WAY1;
        end else if (!valid_4[2]) begin
            victim_4 = WAY2;
        end else if (!valid_4[3]) begin
            victim_4 = WAY3;
        end else if (is_onehot4(replace_way_4)) begin
            victim_4 = replace_way_4;
        end
    end

endmodule

// File: rtl/mmu_l2tlb_refill_ctrl.sv
// Refill and replacement controller for one 4-way L2 TLB set: accepts PTW refills,
// writes the chosen victim into the array and feeds hit/fill touches to the PLRU.
module mmu_l2tlb_refill_ctrl
    import mmu_l2tlb_pkg::*;
#(
    parameter int TAG_W  = 27,
    parameter int DATA_W = 44
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_refill_valid,
    output logic              o_refill_ready,
    input  logic [TAG_W-1:0]  i_refill_tag,
    input  logic [DATA_W-1:0] i_refill_data,
    input  logic              i_hit_valid,
    input  logic [WAYS-1:0]   i_hit_way_4,
    input  logic              i_flush,
    input  logic [WAYS-1:0]   i_replace_way_4,
    output logic [WAYS-1:0]   o_update_way_4,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic [WAYS-1:0]   o_wr_way_4,
    output logic [TAG_W-1:0]  o_wr_tag,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [WAYS-1:0]   o_valid_4,
    output logic              o_refill_done,
    output logic [1:0]        o_dbg_state
);

    // Array write port: o_wr_valid rises in WRITE and stays up with way/tag/data
    // frozen until i_wr_ready is seen high on a rising edge; that edge is the handshake.
    state_e            state_q, state_d;
    logic [WAYS-1:0]   valid_q, update_q, wr_way_q, victim;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;
    logic              done_q;
    logic              accept, wr_hs, fill;

    mmu_l2tlb_victim_sel u_victim_sel (
        .valid_4       (valid_q),
        .replace_way_4 (i_replace_way_4),
        .victim_4      (victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SELECT;
            SELECT:  state_d = i_flush ? IDLE : WRITE;
            WRITE:   if (i_flush || i_wr_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A flush in the handshake cycle cancels the fill entirely.
    always_comb begin
        o_refill_ready = (state_q == IDLE) && !i_flush;
        o_wr_valid     = (state_q == WRITE);
        accept         = i_refill_valid && o_refill_ready;
        wr_hs          = o_wr_valid && i_wr_ready;
        fill           = wr_hs && !i_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q    <= '0;
            data_q   <= '0;
            wr_way_q <= '0;
            valid_q  <= '0;
            update_q <= '0;
            done_q   <= 1'b0;
        end else begin
            if (accept) begin
                tag_q  <= i_refill_tag;
                data_q <= i_refill_data;
            end
            if ((state_q == SELECT) && !i_flush) begin
                wr_way_q <= victim;
            end
            if (i_flush) begin
                valid_q <= '0;
            end else if (fill) begin
                valid_q <= valid_q | wr_way_q;
            end
            if (fill) begin
                update_q <= wr_way_q;
            end else if (i_hit_valid && is_onehot4(i_hit_way_4)) begin
                update_q <= i_hit_way_4;
            end else begin
                update_q <= '0;
            end
            done_q <= fill;
        end
    end

    assign o_update_way_4 = update_q;
    assign o_wr_way_4     = wr_way_q;
    assign o_wr_tag       = tag_q;
    assign o_wr_data      = data_q;
    assign o_valid_4      = valid_q;
    assign o_refill_done  = done_q;
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_mmu_l2tlb_refill_ctrl.sv
// Bench for mmu_l2tlb_refill_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mmu_l2tlb_refill_ctrl;

    localparam int TAG_W  = 27;
    localparam int DATA_W = 44;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_refill_valid;
    logic              o_refill_ready;
    logic [TAG_W-1:0]  i_refill_tag;
    logic [DATA_W-1:0] i_refill_data;
    logic              i_hit_valid;
    logic [3:0]        i_hit_way_4;
    logic              i_flush;
    logic [3:0]        i_replace_way_4;
    logic [3:0]        o_update_way_4;
    logic              o_wr_valid;
    logic              i_wr_ready;
    logic [3:0]        o_wr_way_4;
    logic [TAG_W-1:0]  o_wr_tag;
    logic [DATA_W-1:0] o_wr_data;
    logic [3:0]        o_valid_4;
    logic              o_refill_done;
    logic [1:0]        o_dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mmu_l2tlb_refill_ctrl #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_refill_valid  (i_refill_valid),
        .o_refill_ready  (o_refill_ready),
        .i_refill_tag    (i_refill_tag),
        .i_refill_data   (i_refill_data),
        .i_hit_valid     (i_hit_valid),
        .i_hit_way_4     (i_hit_way_4),
        .i_flush         (i_flush),
        .i_replace_way_4 (i_replace_way_4),
        .o_update_way_4  (o_update_way_4),
        .o_wr_valid      (o_wr_valid),
        .i_wr_ready      (i_wr_ready),
        .o_wr_way_4      (o_wr_way_4),
        .o_wr_tag        (o_wr_tag),
        .o_wr_data       (o_wr_data),
        .o_valid_4       (o_valid_4),
        .o_refill_done   (o_refill_done),
        .o_dbg_state     (o_dbg_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A refill is "in flight" from accept until its write completes or is flushed;
    // its victim becomes known one cycle after accept and the write is then offered.
    logic              m_on = 1'b0;
    logic              m_fl, m_vk, m_done;
    logic [3:0]        m_valid, m_victim, m_upd;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    logic [TAG_W-1:0]  exp_q[$];

    function automatic logic [3:0] pick_victim(input logic [3:0] v, input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) return 4'(1 << i);
        end
        return ($countones(r) == 1) ? r : 4'b0001;
    endfunction

    always @(posedge clk) begin
        logic hs, fill;
        if (rst) begin
            m_on = 1'b1; m_fl = 1'b0; m_vk = 1'b0; m_done = 1'b0;
            m_valid = '0; m_victim = '0; m_upd = '0; m_tag = '0; m_data = '0;
            exp_q.delete();
        end else if (m_on) begin
            hs   = m_fl && m_vk && i_wr_ready;
            fill = hs && !i_flush;
            m_done = fill;
            if (fill) m_upd = m_victim;
            else if (i_hit_valid && $countones(i_hit_way_4) == 1) m_upd = i_hit_way_4;
            else m_upd = '0;
            if (fill) exp_q.push_back(m_tag);
            if (i_flush) begin
                m_fl = 1'b0; m_vk = 1'b0;
            end else if (m_fl && !m_vk) begin
                m_victim = pick_victim(m_valid, i_replace_way_4);
                m_vk = 1'b1;
            end else if (hs) begin
                m_fl = 1'b0;
            end else if (!m_fl && i_refill_valid) begin
                m_fl = 1'b1; m_vk = 1'b0; m_tag = i_refill_tag; m_data = i_refill_data;
            end
            if (i_flush) m_valid = '0;
            else if (fill) m_valid = m_valid | m_victim;
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (m_on) begin
            chk("ready",    64'(o_refill_ready), 64'(!m_fl && !i_flush));
            chk("wr_valid", 64'(o_wr_valid),     64'(m_fl && m_vk));
            chk("wr_way",   64'(o_wr_way_4),     64'(m_victim));
            chk("wr_tag",   64'(o_wr_tag),       64'(m_tag));
            chk("wr_data",  64'(o_wr_data),      64'(m_data));
            chk("valid",    64'(o_valid_4),      64'(m_valid));
            chk("update",   64'(o_update_way_4), 64'(m_upd));
            chk("done",     64'(o_refill_done),  64'(m_done));
            if (o_refill_done === 1'b1) begin
                chk("done_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) chk("done_tag", 64'(o_wr_tag), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Accept a refill and advance into the write phase (accept, select).
    task automatic refill_start(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
        i_refill_valid = 1'b1;
        i_refill_tag   = tag;
        i_refill_data  = data;
        tick();
        i_refill_valid = 1'b0;
        tick();
    endtask

    task automatic randomize_inputs();
        logic [31:0] r32;
        logic [63:0] r64;
        r32 = $urandom();
        r64 = {$urandom(), $urandom()};
        rst             = ($urandom_range(0, 149) == 0);
        i_refill_valid  = ($urandom_range(0, 1) == 1);
        i_refill_tag    = r32[TAG_W-1:0];
        i_refill_data   = r64[DATA_W-1:0];
        i_hit_valid     = ($urandom_range(0, 1) == 1);
        i_hit_way_4     = ($urandom_range(0, 1) == 1) ? 4'(1 << $urandom_range(0, 3))
                                                      : 4'($urandom_range(0, 15));
        i_flush         = ($urandom_range(0, 29) == 0);
        i_wr_ready      = ($urandom_range(0, 9) < 6);
        i_replace_way_4 = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3))
                                                      : 4'($urandom_range(0, 15));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; i_refill_valid = 1'b0; i_refill_tag = '0; i_refill_data = '0;
        i_hit_valid = 1'b0; i_hit_way_4 = '0; i_flush = 1'b0; i_wr_ready = 1'b0;
        i_replace_way_4 = 4'b0001;
        repeat (2) tick();
        chk("rst_valid",    64'(o_valid_4),      64'(0));
        chk("rst_wr_valid", 64'(o_wr_valid),     64'(0));
        chk("rst_done",     64'(o_refill_done),  64'(0));
        chk("rst_update",   64'(o_update_way_4), 64'(0));
        chk("rst_wr_way",   64'(o_wr_way_4),     64'(0));
        chk("rst_ready",    64'(o_refill_ready), 64'(1));
        rst = 1'b0;

        // First refill into an empty set lands in way 0.
        i_wr_ready = 1'b1;
        refill_start(27'h1234, 44'h0AB_CDEF_0123);
        chk("t1_wr_valid", 64'(o_wr_valid), 64'(1));
        chk("t1_wr_way",   64'(o_wr_way_4), 64'(4'b0001));
        chk("t1_wr_tag",   64'(o_wr_tag),   64'(27'h1234));
        chk("t1_wr_data",  64'(o_wr_data),  64'(44'h0AB_CDEF_0123));
        tick();
        chk("t1_done",   64'(o_refill_done),  64'(1));
        chk("t1_update", 64'(o_update_way_4), 64'(4'b0001));
        chk("t1_valid",  64'(o_valid_4),      64'(4'b0001));
        tick();
        chk("t1_done_once", 64'(o_refill_done), 64'(0));

        // Fill ways 1 and 2 back to back.
        refill_start(27'h0000111, 44'h111);
        chk("t2_wr_way", 64'(o_wr_way_4), 64'(4'b0010));
        tick();
        refill_start(27'h0000222, 44'h222);
        chk("t3_wr_way", 64'(o_wr_way_4), 64'(4'b0100));
        tick();

        // Way 3 fill with a coincident hit: the fill touch wins.
        i_wr_ready = 1'b0;
        refill_start(27'h0000333, 44'h333);
        chk("t4_wr_way", 64'(o_wr_way_4), 64'(4'b1000));
        i_hit_valid = 1'b1; i_hit_way_4 = 4'b0010; i_wr_ready = 1'b1;
        tick();
        i_hit_valid = 1'b0; i_wr_ready = 1'b0;
        chk("t4_update", 64'(o_update_way_4), 64'(4'b1000));
        chk("t4_valid",  64'(o_valid_4),      64'(4'b1111));

        // Full set: PLRU victim 0100 with a 5-cycle write stall.
        i_replace_way_4 = 4'b0100;
        refill_start(27'h5A5A, 44'h5_5555_AAAA);
        for (int k = 0; k < 5; k++) begin
            chk("stall_wr_valid", 64'(o_wr_valid),    64'(1));
            chk("stall_wr_way",   64'(o_wr_way_4),    64'(4'b0100));
            chk("stall_wr_tag",   64'(o_wr_tag),      64'(27'h5A5A));
            chk("stall_wr_data",  64'(o_wr_data),     64'(44'h5_5555_AAAA));
            chk("stall_no_done",  64'(o_refill_done), 64'(0));
            tick();
        end
        i_wr_ready = 1'b1;
        tick();
        i_wr_ready = 1'b0;
        chk("stall_done",   64'(o_refill_done),  64'(1));
        chk("stall_update", 64'(o_update_way_4), 64'(4'b0100));
        chk("stall_valid",  64'(o_valid_4),      64'(4'b1111));
        tick();
        chk("stall_done_once", 64'(o_refill_done), 64'(0));

        // Flush coincident with the write handshake.
        refill_start(27'h0F0F, 44'hF0F);
        i_flush = 1'b1; i_wr_ready = 1'b1;
        tick();
        chk("flush_valid",    64'(o_valid_4),      64'(0));
        chk("flush_no_done",  64'(o_refill_done),  64'(0));
        chk("flush_update",   64'(o_update_way_4), 64'(0));
        chk("flush_wr_valid", 64'(o_wr_valid),     64'(0));
        i_flush = 1'b0; i_wr_ready = 1'b0;
        #1;
        chk("flush_ready", 64'(o_refill_ready), 64'(1));

        // Hit vectors: non-one-hot ignored, one-hot reported.
        i_hit_valid = 1'b1; i_hit_way_4 = 4'b0110;
        tick();
        chk("hit_multi", 64'(o_update_way_4), 64'(0));
        i_hit_way_4 = 4'b0001;
        tick();
        chk("hit_one", 64'(o_update_way_4), 64'(4'b0001));
        i_hit_valid = 1'b0;
        tick();
        chk("hit_clear", 64'(o_update_way_4), 64'(0));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            tick();
        end

        // Drain any refill still in flight.
        rst = 1'b0; i_refill_valid = 1'b0; i_flush = 1'b0; i_wr_ready = 1'b1; i_hit_valid = 1'b0;
        repeat (6) tick();
        chk("exp_q_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmu_l2tlb_refill_ctrl.md
Name: mmu_l2tlb_refill_ctrl

Overview:
Refill and replacement controller for one 4-way L2 TLB set. It is the driver side of the 4-way PLRU replacement block: it consumes the PLRU's one-hot victim suggestion and produces the one-hot update stream the PLRU needs.
- Accepts refills from the PTW and picks a victim way (invalid way first, else the PLRU choice).
- Writes the victim into the TLB array through a valid/ready port.
- Tracks per-way valid bits.
- Reports hit and fill touches back to the PLRU.

Parameters:
- TAG_W, 27, width of the VPN tag written into the array.
- DATA_W, 44, width of the PPN and attribute payload written into the array.

Ports:
- clk  in  1  clock; all state is updated on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_refill_valid  in  1  PTW refill request valid.
- o_refill_ready  out  1  controller can accept a refill.
- i_refill_tag  in  TAG_W  refill tag.
- i_refill_data  in  DATA_W  refill payload.
- i_hit_valid  in  1  lookup hit this cycle.
- i_hit_way_4  in  4  one-hot hit way.
- i_flush  in  1  invalidate all ways; abort any pending refill.
- i_replace_way_4  in  4  one-hot victim from the PLRU.
- o_update_way_4  out  4  one-hot touch to the PLRU; 0 means no update.
- o_wr_valid  out  1  array write request.
- i_wr_ready  in  1  array accepts the write.
- o_wr_way_4  out  4  one-hot write way.
- o_wr_tag  out  TAG_W  write tag.
- o_wr_data  out  DATA_W  write payload.
- o_valid_4  out  4  per-way valid bits.
- o_refill_done  out  1  one-cycle pulse when the refill has been written.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; o_valid_4, o_update_way_4, o_wr_way_4, o_wr_tag and o_wr_data become 0.
  - o_wr_valid and o_refill_done become 0.
- FSM states: IDLE, SELECT, WRITE.
- o_refill_ready = (state==IDLE) && !i_flush. It is combinational, so it is 1 in the first cycle after reset.
- IDLE:
  - On i_refill_valid && o_refill_ready, latch tag and data, then go to SELECT.
- SELECT (exactly 1 cycle):
  - Victim = lowest-index way with o_valid_4 bit 0, if any.
  - Otherwise victim = i_replace_way_4, sampled this cycle.
  - If i_replace_way_4 is not one-hot and all ways are valid, use way 0 (4'b0001).
  - Latch the victim into o_wr_way_4, then go to WRITE.
- WRITE:
  - o_wr_valid=1; o_wr_way_4, o_wr_tag and o_wr_data are held stable until i_wr_ready.
  - On the handshake: set o_valid_4[victim]; o_update_way_4 = victim on the next cycle; o_refill_done pulses on the next cycle; go to IDLE.
- Latency: accept edge to first o_wr_valid is 2 cycles. With i_wr_ready tied high, accept to o_refill_done is 3 cycles.
- o_update_way_4 is registered and holds for one cycle only:
  - Priority 1: the fill way, if a WRITE handshake happened in the previous cycle.
  - Priority 2: i_hit_way_4, if i_hit_valid was high and i_hit_way_4 was one-hot in the previous cycle.
  - Otherwise 0.
  - A hit that coincides with a fill handshake is dropped.
  - A non-one-hot hit vector is ignored.
- Flush:
  - o_valid_4 becomes 0 at the next edge.
  - In SELECT or WRITE, return to IDLE with no o_refill_done and no fill update; o_wr_valid drops the next cycle.
  - If i_flush and a WRITE handshake occur in the same cycle, flush wins: the valid bit stays 0 and there is no done pulse.
  - A hit in the flush cycle still produces its update.
- Reset asserted mid-refill discards the refill; no done pulse is produced.
- Back-to-back refills: ready rises in the cycle after o_refill_done would be registered. A new accept can occur the cycle after the WRITE handshake.

Decomposition:
- Package mmu_l2tlb_pkg:
  - WAYS=4.
  - State encoding: IDLE=2'd0, SELECT=2'd1, WRITE=2'd2.
  - One-hot way constants WAY0..WAY3.
  - An is_onehot4 function.
- Sub-module mmu_l2tlb_victim_sel: combinational; inputs valid_4 and replace_way_4; output victim_4 (invalid-first priority with the way-0 fallback).

Test Plan:
- Reset, then refill tag 0x1234 with o_valid_4=0000 and i_wr_ready=1 -> o_wr_way_4=0001 two cycles after accept; o_refill_done and o_update_way_4=0001 one cycle after the handshake; o_valid_4=0001.
- Fill all four ways, then refill with i_replace_way_4=0100 -> victim 0100 is used; o_valid_4 stays 1111; o_update_way_4=0100.
- In WRITE, hold i_wr_ready=0 for 5 cycles -> o_wr_valid, way, tag and data are stable for all 5 cycles; done pulses exactly once after ready.
- i_hit_valid=1 with i_hit_way_4=0010 in the same cycle as a fill handshake on way 1000 -> o_update_way_4=1000 next cycle; the hit update is dropped.
- i_flush during WRITE, coincident with i_wr_ready=1 -> o_valid_4=0000, no o_refill_done, state IDLE, o_refill_ready=1 the next cycle.
- i_hit_valid=1 with i_hit_way_4=0110 -> o_update_way_4=0000; i_hit_way_4=0001 -> o_update_way_4=0001 one cycle later.
